blink_mem_arb: RTL
==================

Name: blink_mem_arb

Overview:
- Arbitrates the 22-bit physical memory bus (ma, chip enables, OE/WE) between two requesters: the Z80, whose address is already bank-translated through SR0-SR3 and COM, and the LCD fetch engine, which reads screen data through PB0-PB3 and SBR.
- Sits between the Blink bank-switch decode and the slot 0-3 memory pins.
- The Z80 has priority. An LCD request that waits too long forces one LCD slot and holds the Z80 off with wait_n.

Parameters:
- STARVE_MAX, 8: number of mck cycles an LCD request may stay pending before an LCD slot is forced (range 1-255).
- ACC_CYC, 2: length of one LCD read access, in mck cycles (range 1-15).

Ports:
- mck  in  1  master clock, 9.83 MHz; all logic samples on its rising edge.
- rin_n  in  1  reset, synchronous, active-low.
- cpu_ma  in  22  Z80 address after bank translation.
- mrq_n  in  1  Z80 MREQ.
- crd_n  in  1  Z80 RD.
- cwr_n  in  1  Z80 WR.
- lcd_req  in  1  LCD fetch request; level-held until lcd_gnt.
- lcd_addr  in  22  LCD physical read address; must be stable while lcd_req is high.
- lcd_gnt  out  1  one-cycle pulse: request accepted and lcd_addr latched.
- lcd_vld  out  1  one-cycle pulse: lcd_data holds the fetched byte.
- lcd_data  out  8  fetched byte, held until the next lcd_vld.
- mem_di  in  8  memory read data bus.
- ma  out  22  physical address to the slots.
- moe_n  out  1  memory output enable.
- mwe_n  out  1  memory write enable.
- ce_n  out  5  chip enables, bit order {se3_n, se2_n, se1_n, irce_n, ipce_n}.
- wait_n  out  1  Z80 WAIT, low while a forced LCD access is in progress.

Behaviour:
- States: IDLE, CPU, LCD.
- force = lcd_req & (starve == STARVE_MAX).
- Transitions out of IDLE:
  - mrq_n=0 and not force: go to CPU.
  - force, or (mrq_n=1 and lcd_req): go to LCD; pulse lcd_gnt that cycle; latch lcd_addr into la; load acc = ACC_CYC-1.
  - Otherwise stay in IDLE.
- CPU: stay while mrq_n=0; mrq_n=1 returns to IDLE.
- LCD:
  - While acc != 0, decrement acc.
  - When acc == 0, capture mem_di into lcd_data and go to IDLE.
  - lcd_vld pulses on the following cycle.
- Bus ownership (combinational from state and inputs):
  - CPU owns the bus when state=CPU, or state=IDLE and not force. Then ma=cpu_ma, moe_n=crd_n|mrq_n, mwe_n=cwr_n|mrq_n.
  - LCD owns the bus when state=LCD. Then ma=la, moe_n=0, mwe_n=1.
- ce_n: decoded from ma, active only when the bus is in use (CPU owner with mrq_n=0, or state=LCD); otherwise all 1.
  - ma[21:19]=000 gives ipce_n=0.
  - ma[21:19]=001 gives irce_n=0.
  - ma[21:20]=01, 10, 11 give se1_n, se2_n, se3_n respectively.
- wait_n=0 exactly when state=LCD and mrq_n=0; otherwise 1.
- starve counter:
  - Increments each cycle that lcd_req=1 and no grant is issued; saturates at STARVE_MAX.
  - Clears on lcd_gnt or when lcd_req=0.
  - Width is ceil(log2(STARVE_MAX+1)).
- Tie-break: in IDLE with mrq_n=0 and lcd_req=1 below saturation, the CPU wins.
- A Z80 cycle already in CPU state is never preempted. A forced grant happens only from IDLE.
- Reset state: IDLE; starve=0, acc=0, la=0; lcd_gnt=0, lcd_vld=0, lcd_data=0; wait_n=1; ce_n=11111.
- Reset asserted during an LCD access aborts it: no lcd_vld, lcd_data stays 0.

Decomposition:
- blink_pkg holds:
  - the state enum {IDLE, CPU, LCD};
  - the ce_n bit indices;
  - slot-decode constants (3'b000 ROM, 3'b001 RAM, 2'b01/10/11 slots 1-3).
- Sub-module blink_slot_dec: inputs ma[21:19] and bus_active, output ce_n[4:0]; purely combinational.

Test Plan:
- Reset: rin_n=0 for 2 cycles -> ce_n=11111, wait_n=1, lcd_gnt=0, lcd_vld=0, lcd_data=00.
- CPU read: cpu_ma=0x080123, mrq_n=0, crd_n=0 -> ma=0x080123, moe_n=0, ce_n=11101 (irce_n=0); mrq_n=1 -> IDLE.
- Idle LCD fetch: mrq_n=1, lcd_req=1, lcd_addr=0x3F1000, mem_di=A5 -> lcd_gnt next cycle; ma=0x3F1000, ce_n=01111 for 2 cycles; lcd_vld pulse with lcd_data=A5.
- Tie-break: mrq_n=0 and lcd_req=1 together with starve=0 -> CPU served first; LCD granted in the first IDLE cycle with mrq_n=1.
- Starvation: back-to-back Z80 cycles, lcd_req held, STARVE_MAX=8 -> after 8 pending cycles, the next IDLE entry with mrq_n=0 grants LCD; wait_n=0 for 2 cycles; Z80 cycle then proceeds.
- Reset mid-LCD: rin_n=0 on the second LCD cycle -> no lcd_vld, state IDLE, lcd_data=00.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared constants for the Blink memory arbiter: FSM encodings, chip-enable
// bit positions and the slot decode of the physical address top bits.
package blink_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CPU  = 2'd1;
    localparam logic [1:0] ST_LCD  = 2'd2;

    typedef logic [1:0] arb_state_t;

    // ce_n bit order {se3_n, se2_n, se1_n, irce_n, ipce_n}
    localparam int CE_IPCE = 0;
    localparam int CE_IRCE = 1;
    localparam int CE_SE1  = 2;
    localparam int CE_SE2  = 3;
    localparam int CE_SE3  = 4;

    localparam logic [2:0] DEC_ROM = 3'b000;
    localparam logic [2:0] DEC_RAM = 3'b001;
    localparam logic [1:0] DEC_SE1 = 2'b01;
    localparam logic [1:0] DEC_SE2 = 2'b10;
    localparam logic [1:0] DEC_SE3 = 2'b11;

    function automatic int starve_width(input int max_cnt);
        return $clog2(max_cnt + 1);
    endfunction

endpackage

// File: rtl/blink_slot_dec.sv
// Chip-enable decode from the top three physical address bits; all enables
// stay high unless a bus owner is actually driving a cycle.
module blink_slot_dec
    import blink_pkg::*;
(
    input  logic [2:0] ma_hi,
    input  logic       bus_active,
    output logic [4:0] ce_n
);

    always_comb begin
        ce_n = 5'b11111;
        if (bus_active) begin
            if (ma_hi == DEC_ROM) begin
                ce_n[CE_IPCE] = 1'b0;
            end else if (ma_hi == DEC_RAM) begin
                ce_n[CE_IRCE] = 1'b0;
            end else begin
                case (ma_hi[2:1])
                    DEC_SE1: ce_n[CE_SE1] = 1'b0;
                    DEC_SE2: ce_n[CE_SE2] = 1'b0;
                    DEC_SE3: ce_n[CE_SE3] = 1'b0;
                    default: ce_n = 5'b11111;
                endcase
            end
        end
    end

endmodule

// File: rtl/blink_mem_arb.sv
// Physical memory bus arbiter between the Z80 and the LCD fetch engine.
// Z80 has priority; a starved LCD request forces one slot and stalls the Z80.
//
//   state | meaning
//   IDLE  | bus free; Z80 may drive combinationally, LCD grant decided here
//   CPU   | Z80 memory cycle in progress, held until MREQ releases
//   LCD   | LCD read access, ACC_CYC cycles, Z80 held off with wait_n
module blink_mem_arb
    import blink_pkg::*;
#(
    parameter int STARVE_MAX = 8,
    parameter int ACC_CYC    = 2
) (
    input  logic        mck,
    input  logic        rin_n,
    input  logic [21:0] cpu_ma,
    input  logic        mrq_n,
    input  logic        crd_n,
    input  logic        cwr_n,
    input  logic        lcd_req,
    input  logic [21:0] lcd_addr,
    output logic        lcd_gnt,
    output logic        lcd_vld,
    output logic [7:0]  lcd_data,
    input  logic [7:0]  mem_di,
    output logic [21:0] ma,
    output logic        moe_n,
    output logic        mwe_n,
    output logic [4:0]  ce_n,
    output logic        wait_n
);

    localparam int SW = starve_width(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [3:0]    ACC_LOAD   = 4'(ACC_CYC - 1);

    arb_state_t     state_q;
    logic [SW-1:0]  starve_q;
    logic [3:0]     acc_q;
    logic [21:0]    la_q;
    logic           lcd_gnt_q;
    logic           lcd_vld_q;
    logic [7:0]     lcd_data_q;

    logic force_lcd;
    logic take_lcd;
    logic cpu_owner;
    logic lcd_owner;
    logic bus_active;

    assign force_lcd = lcd_req && (starve_q == STARVE_TOP);
    assign take_lcd  = (state_q == ST_IDLE) && (force_lcd || (mrq_n && lcd_req));

    always_ff @(posedge mck) begin
        if (!rin_n) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            acc_q      <= '0;
            la_q       <= '0;
            lcd_gnt_q  <= 1'b0;
            lcd_vld_q  <= 1'b0;
            lcd_data_q <= '0;
        end else begin
            lcd_gnt_q <= 1'b0;
            lcd_vld_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (take_lcd) begin
                        state_q   <= ST_LCD;
                        lcd_gnt_q <= 1'b1;
                        la_q      <= lcd_addr;
                        acc_q     <= ACC_LOAD;
                    end else if (!mrq_n) begin
                        state_q <= ST_CPU;
                    end
                end
                ST_CPU: begin
                    if (mrq_n) state_q <= ST_IDLE;
                end
                ST_LCD: begin
                    if (acc_q != 4'd0) begin
                        acc_q <= acc_q - 4'd1;
                    end else begin
                        lcd_data_q <= mem_di;
                        lcd_vld_q  <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Counts cycles an LCD request waits; a grant or a dropped request restarts it.
            if (!lcd_req || take_lcd) begin
                starve_q <= '0;
            end else if (starve_q != STARVE_TOP) begin
                starve_q <= starve_q + SW'(1);
            end
        end
    end

    assign lcd_owner  = (state_q == ST_LCD);
    assign cpu_owner  = (state_q == ST_CPU) || ((state_q == ST_IDLE) && !force_lcd);
    assign bus_active = (cpu_owner && !mrq_n) || lcd_owner;

    always_comb begin
        ma    = cpu_ma;
        moe_n = 1'b1;
        mwe_n = 1'b1;
        if (lcd_owner) begin
            ma    = la_q;
            moe_n = 1'b0;
        end else if (cpu_owner) begin
            moe_n = crd_n | mrq_n;
            mwe_n = cwr_n | mrq_n;
        end
    end

    assign wait_n   = !(lcd_owner && !mrq_n);
    assign lcd_gnt  = lcd_gnt_q;
    assign lcd_vld  = lcd_vld_q;
    assign lcd_data = lcd_data_q;

    blink_slot_dec u_slot_dec (
        .ma_hi      (ma[21:19]),
        .bus_active (bus_active),
        .ce_n       (ce_n)
    );

endmodule
